// File: rtl/mult_share_sched_if.sv
// Client-side and multiplier-side bus of the shared multiplier scheduler.
interface mult_share_sched_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 36,
    parameter int unsigned MAX      = 217
);
    localparam int unsigned CNT_W = $clog2(MAX);

    logic [CHANNELS-1:0]       req;
    logic [CHANNELS*WIDTH-1:0] dataa;
    logic [CHANNELS*WIDTH-1:0] datab;
    logic [CHANNELS-1:0]       grant;
    logic [WIDTH-1:0]          mult_dataa;
    logic [WIDTH-1:0]          mult_datab;
    logic [2*WIDTH-1:0]        mult_result;
    logic [2*WIDTH-1:0]        result;
    logic [CHANNELS-1:0]       result_valid;
    logic [CNT_W-1:0]          count;
    logic                      wrap;

    modport master (
        output req, dataa, datab, mult_result,
        input  grant, mult_dataa, mult_datab, result, result_valid, count, wrap
    );

    modport slave (
        input  req, dataa, datab, mult_result,
        output grant, mult_dataa, mult_datab, result, result_valid, count, wrap
    );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin time-sharing of one pipelined signed multiplier, with owner
// tags tracked alongside the multiplier latency, plus a modulo-MAX step counter.
module mult_share_sched #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 36,
    parameter int unsigned LAT      = 5,
    parameter int unsigned MAX      = 217
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    mult_share_sched_if.slave bus
);
    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX);

    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    next_ptr;
    logic [IDX_W-1:0]    gidx;
    logic [IDX_W-1:0]    cand;
    logic                gfound;
    logic [CHANNELS-1:0] gnt;
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;
    logic                at_top;

    logic [LAT:0]        tag_v;
    logic [IDX_W-1:0]    tag_idx [LAT+1];

    // First requester at or above ptr, searching modulo CHANNELS.
    always_comb begin
        gnt    = '0;
        gidx   = '0;
        cand   = '0;
        gfound = 1'b0;
        if (en) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cand = IDX_W'((32'(ptr) + i) % CHANNELS);
                if (!gfound && bus.req[cand]) begin
                    gfound    = 1'b1;
                    gidx      = cand;
                    gnt[cand] = 1'b1;
                end
            end
        end
    end

    assign bus.grant = gnt;
    assign next_ptr  = IDX_W'((32'(gidx) + 1) % CHANNELS);
    assign sel_a     = bus.dataa[32'(gidx)*WIDTH +: WIDTH];
    assign sel_b     = bus.datab[32'(gidx)*WIDTH +: WIDTH];
    assign at_top    = (bus.count == CNT_W'(MAX - 1));

    // Reset clears tag valids, so products already in the multiplier are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr              <= '0;
            bus.mult_dataa   <= '0;
            bus.mult_datab   <= '0;
            bus.result       <= '0;
            bus.result_valid <= '0;
            bus.count        <= '0;
            bus.wrap         <= 1'b0;
            tag_v            <= '0;
            for (int unsigned i = 0; i <= LAT; i++) tag_idx[i] <= '0;
        end else if (en) begin
            if (gfound) ptr <= next_ptr;
            bus.mult_dataa <= gfound ? sel_a : '0;
            bus.mult_datab <= gfound ? sel_b : '0;

            tag_v[0]   <= gfound;
            tag_idx[0] <= gidx;
            for (int unsigned i = 1; i <= LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end

            // Tail stage lines up with the product leaving the multiplier.
            if (tag_v[LAT]) begin
                bus.result       <= bus.mult_result;
                bus.result_valid <= CHANNELS'(1) << tag_idx[LAT];
            end else begin
                bus.result_valid <= '0;
            end

            bus.wrap  <= at_top;
            bus.count <= at_top ? '0 : bus.count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched with a behavioural pipelined multiplier.
module tb_mult_share_sched;
    localparam int CH  = 4;
    localparam int W   = 36;
    localparam int LAT = 5;
    localparam int MAX = 217;
    localparam int MAX5 = 5;

    typedef struct {
        logic [CH-1:0]  rv;
        logic [2*W-1:0] res;
        int             k;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    mult_share_sched_if #(.CHANNELS(CH), .WIDTH(W), .MAX(MAX)) bus ();
    mult_share_sched_if #(.CHANNELS(2), .WIDTH(8), .MAX(MAX5)) bus5 ();

    mult_share_sched #(.CHANNELS(CH), .WIDTH(W), .LAT(LAT), .MAX(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus)
    );
    mult_share_sched #(.CHANNELS(2), .WIDTH(8), .LAT(2), .MAX(MAX5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus5)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t q[$];
    int ecnt  = 0;
    int ptr_m = 0;
    int cnt_m = 0;
    logic wrap_m = 1'b0;
    int cnt5_m = 0;
    logic wrap5_m = 1'b0;
    logic [W-1:0] opa [CH];
    logic [W-1:0] opb [CH];

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] x;
        logic signed [2*W-1:0] y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    // Behavioural stand-in for array_mult: LAT enabled stages.
    logic [2*W-1:0] mpipe [LAT];
    assign bus.mult_result  = mpipe[LAT-1];
    assign bus5.req         = '0;
    assign bus5.dataa       = '0;
    assign bus5.datab       = '0;
    assign bus5.mult_result = '0;

    always @(posedge clk) begin
        if (en) begin
            mpipe[0] <= prod(bus.mult_dataa, bus.mult_datab);
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
            ecnt <= ecnt + 1;
        end
        if (!rst_n) begin
            cnt_m <= 0; wrap_m <= 1'b0; cnt5_m <= 0; wrap5_m <= 1'b0;
        end else if (en) begin
            wrap_m  <= (cnt_m == MAX - 1);
            cnt_m   <= (cnt_m == MAX - 1) ? 0 : cnt_m + 1;
            wrap5_m <= (cnt5_m == MAX5 - 1);
            cnt5_m  <= (cnt5_m == MAX5 - 1) ? 0 : cnt5_m + 1;
        end
    end

    // Output monitor: a result is due LAT+2 enabled edges after its grant.
    always @(negedge clk) begin
        if (rst_n) begin
            if (en) begin
                if (q.size() > 0 && ecnt == q[0].k + LAT + 2) begin
                    exp_t e;
                    e = q.pop_front();
                    check("result_valid", 72'(bus.result_valid), 72'(e.rv));
                    check("result", bus.result, e.res);
                end else begin
                    check("result_valid_idle", 72'(bus.result_valid), 72'd0);
                end
            end
            check("count", 72'(bus.count), 72'(cnt_m));
            check("wrap", 72'(bus.wrap), 72'(wrap_m));
            check("count5", 72'(bus5.count), 72'(cnt5_m));
            check("wrap5", 72'(bus5.wrap), 72'(wrap5_m));
        end
    end

    task automatic step(input logic e, input logic [CH-1:0] r);
        logic [CH-1:0] eg;
        int g;
        en      = e;
        bus.req = r;
        for (int c = 0; c < CH; c++) begin
            bus.dataa[c*W +: W] = opa[c];
            bus.datab[c*W +: W] = opb[c];
        end
        @(negedge clk);
        eg = '0;
        g  = -1;
        if (e && r != '0) begin
            for (int i = 0; i < CH; i++) begin
                int c;
                c = (ptr_m + i) % CH;
                if (g < 0 && r[c]) g = c;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        check("grant", 72'(bus.grant), 72'(eg));
        if (g >= 0) begin
            q.push_back('{eg, prod(opa[g], opb[g]), ecnt});
            ptr_m = (g + 1) % CH;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n   = 1'b0;
        bus.req = '0;
        repeat (cycles) @(posedge clk);
        #1;
        q.delete();
        ptr_m = 0;
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        for (int c = 0; c < CH; c++) begin
            opa[c] = {$urandom, $urandom};
            opb[c] = {$urandom, $urandom};
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        bus.req = '0;
        bus.dataa = '0;
        bus.datab = '0;
        for (int c = 0; c < CH; c++) begin opa[c] = '0; opb[c] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result_valid", 72'(bus.result_valid), 72'd0);
        check("rst_result", bus.result, 72'd0);
        check("rst_count", 72'(bus.count), 72'd0);
        check("rst_wrap", 72'(bus.wrap), 72'd0);
        check("rst_mult_dataa", 72'(bus.mult_dataa), 72'd0);
        check("rst_grant", 72'(bus.grant), 72'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request on channel 2: 3*4.
        opa[2] = 36'd3; opb[2] = 36'd4;
        step(1'b1, 4'b0100);
        repeat (9) step(1'b1, 4'b0000);

        // Signed operands on channel 0: -2*3.
        opa[0] = -36'sd2; opb[0] = 36'd3;
        step(1'b1, 4'b0001);
        repeat (9) step(1'b1, 4'b0000);

        // Round-robin from ptr=0 with all channels requesting.
        do_reset(1);
        rand_ops();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b1111);
            rand_ops();
        end
        repeat (9) step(1'b1, 4'b0000);

        // Stall of three cycles two cycles after a grant.
        step(1'b1, 4'b0010);
        repeat (2) step(1'b1, 4'b0000);
        repeat (3) step(1'b0, 4'b1111);
        repeat (9) step(1'b1, 4'b0000);

        // Reset with three products in flight.
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(1'b1, 4'b1111);
        end
        do_reset(1);
        check("post_rst_count", 72'(bus.count), 72'd0);
        rand_ops();
        step(1'b1, 4'b1000);
        step(1'b1, 4'b1111);
        repeat (9) step(1'b1, 4'b0000);

        // Counter wrap from reset.
        do_reset(1);
        repeat (MAX - 1) step(1'b1, 4'b0000);
        check("count_top", 72'(bus.count), 72'd216);
        step(1'b1, 4'b0000);
        check("count_wrapped", 72'(bus.count), 72'd0);
        check("wrap_pulse", 72'(bus.wrap), 72'd1);
        step(1'b1, 4'b0000);
        check("wrap_cleared", 72'(bus.wrap), 72'd0);

        // Random traffic with random stalls, including extreme operands.
        for (int i = 0; i < 200; i++) begin
            rand_ops();
            if ($urandom_range(0, 7) == 0) begin
                opa[0] = {1'b1, {(W-1){1'b0}}};
                opb[0] = {1'b1, {(W-1){1'b0}}};
            end
            step($urandom_range(0, 3) != 0, 4'($urandom));
        end
        repeat (LAT + 5) step(1'b1, 4'b0000);
        check("drain", 72'(q.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Parametrised front end that time-shares one pipelined signed multiplier (the `array_mult` instance) among CHANNELS requesting blocks. It arbitrates round-robin, registers the winning operands into the multiplier, and tracks each product's owner through a tag pipeline matched to the multiplier latency. It returns each product one-hot tagged to its owner. It also owns the modulo-MAX step counter that sequences the `lt_block`-class datapaths, and adds a wrap pulse.

## Interface
Parameters:
- CHANNELS, 4: number of requesting clients (2..8).
- WIDTH, 36: operand width, signed two's complement.
- LAT, 5: enabled-cycle latency of the external multiplier, from operand input to result output.
- MAX, 217: step-counter modulus.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  global advance enable; the multiplier `en` is tied to the same net.
- req  in  CHANNELS  per-channel request; held with operands until granted.
- dataa  in  CHANNELS*WIDTH  packed operand A; channel i is at [i*WIDTH +: WIDTH].
- datab  in  CHANNELS*WIDTH  packed operand B, same packing.
- grant  out  CHANNELS  one-hot acceptance, combinational.
- mult_dataa  out  WIDTH  registered operand A to the shared multiplier.
- mult_datab  out  WIDTH  registered operand B to the shared multiplier.
- mult_result  in  2*WIDTH  product from the shared multiplier.
- result  out  2*WIDTH  registered product.
- result_valid  out  CHANNELS  one-hot owner of `result`.
- count  out  $clog2(MAX)  step counter.
- wrap  out  1  one-cycle pulse when `count` wraps.

## Operation
- **Arbitration.** A priority pointer `ptr` selects the first requesting channel at or above `ptr`, searching modulo CHANNELS.
  - grant = 0 when en=0 or req=0.
  - On an enabled edge with a grant to channel g, `ptr` becomes (g+1) mod CHANNELS. Otherwise `ptr` holds.
- **Operand stage.** On an enabled edge, mult_dataa/mult_datab load the granted channel's operands. With no grant they load 0.
- **Tag pipeline.**
  - Depth LAT+1, each stage {valid, channel index}.
  - Stage 0 loads {|grant, index(grant)}.
  - All stages shift only on enabled edges.
- **Result stage.** On an enabled edge:
  - If the tail stage is valid: result <= mult_result, and result_valid <= one-hot of the tail index.
  - Otherwise result_valid <= 0, and result holds its value.
- **Stall (en=0).** Every register in the block holds its value, including result_valid. A consumer therefore samples result_valid only when en=1.
- **Step counter.** On an enabled edge, count increments, wrapping from MAX-1 to 0.
  - wrap is registered: it is 1 for the cycle after the MAX-1 to 0 transition, otherwise 0.
  - Under en=0, wrap holds its value, like all other state.
- **Arithmetic.** The product is the full 2*WIDTH signed result, passed through unchanged. The block performs no truncation or saturation.
- **Reset (rst_n=0 on a rising edge), regardless of en:**
  - ptr, count, wrap, mult_dataa, mult_datab, result, result_valid, and all tag valids go to 0.
  - Products already inside the multiplier are discarded, because their tags are cleared.
  - Reset has priority over en.

## Timing
- grant is combinational from req, ptr and en in the same cycle. A requester sees grant and may drop or change req from the next cycle.
- Latency: a grant in enabled cycle t produces result_valid and result in the cycle after the (LAT+2)th enabled edge counted from t's edge. With en held high this is cycle t+LAT+2.
- Throughput: one product per enabled cycle, sustained.
- Fairness: with every channel requesting continuously, each channel is granted once per CHANNELS enabled cycles.
- Boundary cases:
  - Simultaneous grant and tail-valid on the same edge are independent; both take effect.
  - A request arriving during en=0 is not granted until en=1.
  - Deasserting req for an already granted channel has no effect on its in-flight product.
  - With CHANNELS=1, ptr is constant 0.
- Reset values of all outputs: grant follows req & en combinationally and is 0 during reset; every other output is 0.

## Test plan
- Single request, default parameters: req=4'b0100, dataa[2]=3, datab[2]=4 for one cycle t with en=1.
  - grant=4'b0100 in cycle t.
  - result=72'd12 and result_valid=4'b0100 at cycle t+7; result_valid=0 from t+8.
- Signed operands: dataa=-2, datab=3 on channel 0.
  - result = 72'hFF_FFFF_FFFF_FFFF_FFFA with result_valid=4'b0001.
- Round-robin: req=4'b1111 held for 8 cycles, ptr=0.
  - grants 0,1,2,3,0,1,2,3.
  - results return in the same order, 7 cycles later, back-to-back.
- Stall: insert en=0 for 3 cycles, two cycles after a grant.
  - The result appears at t+10.
  - grant=0 during the stall.
  - count does not advance during the stall.
- Reset mid-flight: three grants issued, then rst_n=0 for one edge.
  - No result_valid asserts for those products.
  - count=0, ptr=0.
  - A new request afterwards returns correctly.
- Counter wrap: run 217 enabled cycles from reset.
  - count goes 216 then 0.
  - wrap=1 for exactly the cycle count=0 first appears.
  - Also check wrap with MAX=5.
